tach_speed_ctrl: RTL and testbench
==================================

# tach_speed_ctrl

Closed-loop motor speed controller for the HB3 H-bridge path. Consumes per-window pulse counts from the tachometer, steps an 8-bit PWM duty toward a target speed, and sequences direction reversals through coast and dead-time states. Sits between the register interface (target/enable) and the H-bridge pins (PWM, direction).

## Interface
Parameters:
- CLOCK_FREQ, 100000000: system clock in Hz.
- PWM_DIV, 20: clocks per PWM tick; PWM period = 256 × PWM_DIV clocks.
- DUTY_STEP, 1: duty increment/decrement per speed window, 1..255.
- SPEED_TOL, 2: dead band in counts around target_speed.
- DEADTIME_CYCLES, 1000000: DWELL length in clocks (10 ms at 100 MHz).
- STALL_WINDOWS, 8: consecutive zero-speed windows at full duty that declare a stall (only with macro).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- system_reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 0 forces IDLE.
- target_speed  in  16  desired pulses per tachometer window.
- target_dir  in  1  requested direction.
- speed_valid  in  1  one-cycle strobe, speed_count valid.
- speed_count  in  32  pulses counted in the last window.
- pwm_out  out  1  H-bridge enable PWM.
- dir_out  out  1  H-bridge direction.
- duty  out  8  current duty register.
- state  out  3  FSM state encoding (package enum).
- at_speed  out  1  last window within tolerance.
- fault  out  1  stall fault (0 when macro absent).

## Operation
- Reset: state=IDLE, duty=0, dir_out=0, pwm_out=0, at_speed=0, fault=0, all counters 0.
- IDLE: duty=0. enable=1 → RUN if target_dir==dir_out, else COAST.
- RUN, on speed_valid: compare speed_count against {16'b0,target_speed} at 33-bit width.
  - speed_count < target−SPEED_TOL (floored at 0): duty += DUTY_STEP, saturate 255; at_speed=0.
  - speed_count > target+SPEED_TOL: duty −= DUTY_STEP, saturate 0; at_speed=0.
  - else hold duty; at_speed=1.
- RUN with target_dir≠dir_out (sampled every clock) → COAST; direction check has priority over a same-cycle speed_valid adjustment.
- COAST: duty=0, at_speed=0; on speed_valid with speed_count==0 → DWELL.
- DWELL: counts DEADTIME_CYCLES clocks with duty=0; on terminal count dir_out<=target_dir, → RUN with duty=0.
- target_dir toggling back during COAST/DWELL: sequence still completes; dir_out takes target_dir at DWELL exit.
- enable=0 in any state → IDLE next clock, duty=0, dir_out retained, DWELL counter cleared.
- target_speed=0 in RUN: duty ramps down to 0 and holds.

## Timing
- FSM, duty, at_speed registered; update on the clock edge after speed_valid/enable/target_dir sampled.
- PWM: 8-bit phase counter advances once per PWM_DIV clocks; pwm_out = (phase < duty_latched), registered. duty_latched loads duty when phase wraps 255→0; duty change appears at next PWM period start, no mid-period glitch.
- duty=0 → pwm_out constantly 0; duty=255 → high 255 of 256 ticks.
- Any state other than RUN forces pwm_out=0 on the next clock, bypassing period latch.
- DWELL exit exactly DEADTIME_CYCLES clocks after entry.

## Configuration
- TACH_CTRL_STALL_DETECT_EN defined: in RUN, each speed_valid with duty==255 and speed_count==0 increments a stall counter, any other window clears it; reaching STALL_WINDOWS → FAULT state: duty=0, pwm_out=0, fault=1. FAULT exits only via enable=0 (→ IDLE, fault cleared) or reset.
- Undefined: no FAULT state or stall counter; fault tied 0.

## Structure
- Package tach_ctrl_pkg: state enum (IDLE, RUN, COAST, DWELL, FAULT), DUTY_W=8, PWM_STEPS=256 constants.
- Sub-module tach_pwm_gen: prescaler, phase counter, duty latch, pwm output; inputs duty and force_off.

## Test plan
- Reset mid-RUN with duty=100 → all outputs to reset values asynchronously, pwm_out=0 immediately.
- enable=1, target_speed=50, dir match, speed_count=10 for 5 windows → duty 0→5, one step per speed_valid, at_speed=0.
- RUN duty=255, speed_count=10 below target → duty holds 255 (saturation); duty=0 with speed_count=80 → holds 0.
- speed_count=51 with target 50, TOL 2 → duty unchanged, at_speed=1.
- target_dir flip in RUN → COAST, duty=0; speed_count=3 stays COAST; speed_count=0 → DWELL; dir_out changes exactly DEADTIME_CYCLES later, state=RUN.
- Macro on: duty=255, 8 windows speed_count=0 → fault=1, pwm_out=0; enable low → IDLE, fault=0.

Source files
------------

// File: rtl/tach_ctrl_pkg.sv
// Shared types and constants for the tachometer speed controller.
package tach_ctrl_pkg;

  localparam int DUTY_W    = 8;
  localparam int PWM_STEPS = 256;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_COAST = 3'd2,
    ST_DWELL = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/tach_pwm_gen.sv
// PWM generator: prescaler, 8-bit phase counter, period-aligned duty latch.
// force_off drops the output on the next clock and clears the latch, so a
// return to RUN never replays a stale duty from an earlier period.
module tach_pwm_gen
  import tach_ctrl_pkg::*;
#(
  parameter int PWM_DIV = 20
) (
  input  logic              clock,
  input  logic              system_reset,
  input  logic [DUTY_W-1:0] duty,
  input  logic              force_off,
  output logic              pwm_out
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] phase_q, phase_d;
  logic [DUTY_W-1:0] latched_q, latched_d;
  logic              pwm_q, pwm_d;
  logic              tick;

  assign tick = (pre_q == '0);

  // Next-state for prescaler, phase, duty latch and output compare.
  always_comb begin
    pre_d     = tick ? PRE_W'(PWM_DIV - 1) : pre_q - 1'b1;
    phase_d   = tick ? phase_q + 8'd1 : phase_q;
    latched_d = latched_q;
    if (force_off) begin
      latched_d = '0;
    end else if (tick && (phase_q == DUTY_MAX)) begin
      latched_d = duty;
    end
    pwm_d = !force_off && (phase_q < latched_q);
  end

  // PWM state registers.
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      pre_q     <= '0;
      phase_q   <= '0;
      latched_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      latched_q <= latched_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/tach_speed_ctrl.sv
// Closed-loop motor speed controller: steps PWM duty toward target_speed
// per tachometer window and sequences reversals via COAST and DWELL.
// Optional stall detection is built when TACH_CTRL_STALL_DETECT_EN is defined.
//
//   state | meaning
//   IDLE  | disabled, duty 0
//   RUN   | closed-loop duty adjustment each speed window
//   COAST | bridge off, waiting for a zero-speed window
//   DWELL | dead time before driving the new direction
//   FAULT | stall detected, output off until enable drops
module tach_speed_ctrl
  import tach_ctrl_pkg::*;
#(
  parameter int CLOCK_FREQ      = 100000000,
  parameter int PWM_DIV         = 20,
  parameter int DUTY_STEP       = 1,
  parameter int SPEED_TOL       = 2,
  parameter int DEADTIME_CYCLES = 1000000,
  parameter int STALL_WINDOWS   = 8
) (
  input  logic        clock,
  input  logic        system_reset,
  input  logic        enable,
  input  logic [15:0] target_speed,
  input  logic        target_dir,
  input  logic        speed_valid,
  input  logic [31:0] speed_count,
  output logic        pwm_out,
  output logic        dir_out,
  output logic [7:0]  duty,
  output logic [2:0]  state,
  output logic        at_speed,
  output logic        fault
);

  if (DUTY_STEP < 1 || DUTY_STEP > 255 || CLOCK_FREQ <= 0) begin : g_bad_param
    $error("tach_speed_ctrl: DUTY_STEP must be 1..255 and CLOCK_FREQ positive");
  end

  localparam int CNT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES + 1) : 1;
  localparam logic [32:0] TOL33 = 33'(SPEED_TOL);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              at_q, at_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [32:0]       sc33, tgt33, lo33, hi33;
  logic [DUTY_W:0]   inc9;
  logic [DUTY_W-1:0] duty_up, duty_dn;

`ifdef TACH_CTRL_STALL_DETECT_EN
  localparam int SW_W = $clog2(STALL_WINDOWS + 1);
  logic [SW_W-1:0] stall_q, stall_d;
  logic            fault_q, fault_d;
`endif

  // Window compare at 33 bits so target+tolerance can never wrap.
  always_comb begin
    sc33    = {1'b0, speed_count};
    tgt33   = {17'b0, target_speed};
    lo33    = (tgt33 > TOL33) ? tgt33 - TOL33 : '0;
    hi33    = tgt33 + TOL33;
    inc9    = {1'b0, duty_q} + 9'(DUTY_STEP);
    duty_up = inc9[DUTY_W] ? DUTY_MAX : inc9[DUTY_W-1:0];
    duty_dn = (duty_q < 8'(DUTY_STEP)) ? '0 : duty_q - 8'(DUTY_STEP);
  end

  // Sequencing FSM next-state and datapath.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    at_d    = at_q;
    cnt_d   = cnt_q;
`ifdef TACH_CTRL_STALL_DETECT_EN
    stall_d = stall_q;
    fault_d = fault_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      at_d    = 1'b0;
      cnt_d   = '0;
`ifdef TACH_CTRL_STALL_DETECT_EN
      stall_d = '0;
      fault_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d  = '0;
          at_d    = 1'b0;
          state_d = (target_dir == dir_q) ? ST_RUN : ST_COAST;
        end
        ST_RUN: begin
          if (target_dir != dir_q) begin
            state_d = ST_COAST;
            duty_d  = '0;
            at_d    = 1'b0;
`ifdef TACH_CTRL_STALL_DETECT_EN
            stall_d = '0;
`endif
          end else if (speed_valid) begin
            if (sc33 < lo33) begin
              duty_d = duty_up;
              at_d   = 1'b0;
            end else if (sc33 > hi33) begin
              duty_d = duty_dn;
              at_d   = 1'b0;
            end else begin
              at_d = 1'b1;
            end
`ifdef TACH_CTRL_STALL_DETECT_EN
            if (duty_q == DUTY_MAX && speed_count == '0) begin
              if (stall_q == SW_W'(STALL_WINDOWS - 1)) begin
                state_d = ST_FAULT;
                duty_d  = '0;
                at_d    = 1'b0;
                fault_d = 1'b1;
                stall_d = '0;
              end else begin
                stall_d = stall_q + 1'b1;
              end
            end else begin
              stall_d = '0;
            end
`endif
          end
        end
        ST_COAST: begin
          duty_d = '0;
          at_d   = 1'b0;
          if (speed_valid && speed_count == '0) begin
            state_d = ST_DWELL;
            cnt_d   = CNT_W'(DEADTIME_CYCLES - 1);
          end
        end
        ST_DWELL: begin
          duty_d = '0;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
            dir_d   = target_dir;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_FAULT: begin
          duty_d = '0;
          at_d   = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      at_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef TACH_CTRL_STALL_DETECT_EN
      stall_q <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      at_q    <= at_d;
      cnt_q   <= cnt_d;
`ifdef TACH_CTRL_STALL_DETECT_EN
      stall_q <= stall_d;
      fault_q <= fault_d;
`endif
    end
  end

  tach_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clock        (clock),
    .system_reset (system_reset),
    .duty         (duty_q),
    .force_off    (state_q != ST_RUN),
    .pwm_out      (pwm_out)
  );

  assign dir_out  = dir_q;
  assign duty     = duty_q;
  assign state    = state_q;
  assign at_speed = at_q;
`ifdef TACH_CTRL_STALL_DETECT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_tach_speed_ctrl.sv
// Scoreboard bench for tach_speed_ctrl with a window-level reference model.
module tb_tach_speed_ctrl;
  import tach_ctrl_pkg::*;

  localparam int DIV    = 2;
  localparam int STEP   = 1;
  localparam int TOL    = 2;
  localparam int DEAD   = 40;
  localparam int STALLW = 8;

  logic        clock = 1'b0;
  logic        system_reset;
  logic        enable;
  logic [15:0] target_speed;
  logic        target_dir;
  logic        speed_valid;
  logic [31:0] speed_count;
  logic        pwm_out, dir_out, at_speed, fault;
  logic [7:0]  duty;
  logic [2:0]  state;

  tach_speed_ctrl #(
    .CLOCK_FREQ      (100000000),
    .PWM_DIV         (DIV),
    .DUTY_STEP       (STEP),
    .SPEED_TOL       (TOL),
    .DEADTIME_CYCLES (DEAD),
    .STALL_WINDOWS   (STALLW)
  ) dut (
    .clock        (clock),
    .system_reset (system_reset),
    .enable       (enable),
    .target_speed (target_speed),
    .target_dir   (target_dir),
    .speed_valid  (speed_valid),
    .speed_count  (speed_count),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .duty         (duty),
    .state        (state),
    .at_speed     (at_speed),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int     duty;
    bit     at;
    state_t st;
  } exp_t;

  exp_t   sbq[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // Reference model, advanced once per speed window.
  int     m_duty  = 0;
  bit     m_at    = 0;
  state_t m_st    = ST_IDLE;
  int     m_stall = 0;
  bit     m_fault = 0;
  bit     m_dir   = 0;
  longint m_tgt   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic window(input longint sc);
    longint lo, hi;
    bit     stall_hit;
    exp_t   e;
    @(negedge clock);
    speed_count  = sc[31:0];
    target_speed = m_tgt[15:0];
    speed_valid  = 1'b1;
    if (m_st == ST_RUN) begin
      lo = (m_tgt > TOL) ? m_tgt - TOL : 0;
      hi = m_tgt + TOL;
      stall_hit = (m_duty == 255) && (sc == 0);
      if (sc < lo) begin
        m_duty = (m_duty + STEP > 255) ? 255 : m_duty + STEP;
        m_at   = 0;
      end else if (sc > hi) begin
        m_duty = (m_duty < STEP) ? 0 : m_duty - STEP;
        m_at   = 0;
      end else begin
        m_at = 1;
      end
`ifdef TACH_CTRL_STALL_DETECT_EN
      if (stall_hit) begin
        m_stall++;
        if (m_stall >= STALLW) begin
          m_st = ST_FAULT; m_duty = 0; m_at = 0; m_fault = 1; m_stall = 0;
        end
      end else begin
        m_stall = 0;
      end
`else
      if (stall_hit) m_stall = 0;
`endif
    end else if (m_st == ST_COAST && sc == 0) begin
      m_st = ST_DWELL;
    end
    e.duty = m_duty; e.at = m_at; e.st = m_st;
    sbq.push_back(e);
    @(negedge clock);
    speed_valid = 1'b0;
  endtask

  // Monitor: the DUT presents a new window result on the clock after speed_valid.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (speed_valid && !system_reset) begin
        @(negedge clock);
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: DUT produced a window result with no expectation queued");
        end else begin
          e = sbq.pop_front();
          check("sb_duty",  duty,     e.duty);
          check("sb_at",    at_speed, e.at);
          check("sb_state", state,    3'(e.st));
        end
      end
    end
  end

  task automatic pwm_check(input string name, input int dexp);
    int cnt;
    repeat (2 * 256 * DIV) @(negedge clock);
    cnt = 0;
    repeat (256 * DIV) begin
      @(negedge clock);
      if (pwm_out) cnt++;
    end
    check(name, cnt, dexp * DIV);
  endtask

  task automatic reenable();
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_state", state, 3'(ST_IDLE));
    check("idle_fault", fault, 0);
    check("idle_dir_kept", dir_out, m_dir);
    m_st = ST_IDLE; m_duty = 0; m_at = 0; m_stall = 0; m_fault = 0;
    enable = 1'b1;
    repeat (2) @(negedge clock);
    m_st = (target_dir == m_dir) ? ST_RUN : ST_COAST;
    check("reenable_state", state, 3'(m_st));
  endtask

  task automatic measure_dwell(input string name);
    int n;
    n = 0;
    while (dir_out != target_dir && n < 4 * DEAD) begin
      @(negedge clock);
      n++;
    end
    check(name, n, DEAD);
    m_dir = target_dir;
    m_st  = ST_RUN;
    check({name, "_state"}, state, 3'(ST_RUN));
    check({name, "_duty"}, duty, 0);
  endtask

  initial begin
    longint sc;
    int     r;
    system_reset = 1'b1; enable = 1'b0; target_speed = '0; target_dir = 1'b0;
    speed_valid = 1'b0; speed_count = '0;
    repeat (3) @(negedge clock);
    check("rst_state", state, 3'(ST_IDLE));
    check("rst_duty",  duty, 0);
    check("rst_pwm",   pwm_out, 0);
    check("rst_dir",   dir_out, 0);
    check("rst_at",    at_speed, 0);
    check("rst_fault", fault, 0);
    system_reset = 1'b0;

    // Start-up ramp at one step per window.
    m_tgt = 50; target_speed = 16'd50; enable = 1'b1;
    repeat (2) @(negedge clock);
    m_st = ST_RUN;
    check("run_entry", state, 3'(ST_RUN));
    repeat (5) window(10);
    check("ramp_duty5", duty, 5);

    // Dead-band edges around target 50 with tolerance 2.
    window(51); window(52); window(53); window(48); window(47);

    // Ramp to 100 and check the PWM high time.
    m_tgt = 1000;
    while (m_duty < 100) window(10);
    pwm_check("pwm_duty100", m_duty);

    // Asynchronous reset mid-RUN.
    @(negedge clock);
    #2 system_reset = 1'b1;
    #1;
    check("arst_state", state, 3'(ST_IDLE));
    check("arst_duty",  duty, 0);
    check("arst_pwm",   pwm_out, 0);
    check("arst_dir",   dir_out, 0);
    check("arst_at",    at_speed, 0);
    @(negedge clock);
    system_reset = 1'b0;
    m_duty = 0; m_at = 0; m_stall = 0; m_fault = 0; m_dir = 0;
    repeat (2) @(negedge clock);
    m_st = ST_RUN;
    check("post_rst_run", state, 3'(ST_RUN));

    // Saturate at full duty.
    repeat (260) window(10);
    check("sat_duty255", duty, 255);
    pwm_check("pwm_duty255", m_duty);

`ifdef TACH_CTRL_STALL_DETECT_EN
    repeat (STALLW - 1) window(0);
    check("stall_not_yet", fault, 0);
    window(0);
    @(negedge clock);
    check("stall_fault", fault, 1);
    check("stall_pwm", pwm_out, 0);
    reenable();
`else
    window(0);
    check("no_stall_fault", fault, 0);
`endif

    // Zero target ramps down to 0 and holds.
    m_tgt = 0;
    repeat (260) window(80);
    window(0); window(2); window(3);
    check("zero_tgt_duty", duty, 0);
    pwm_check("pwm_duty0", m_duty);

    // Randomized windows.
    for (int i = 0; i < 400; i++) begin
      if (i % 20 == 0) m_tgt = longint'($urandom_range(0, 400));
      r = $urandom_range(0, 9);
      if (r < 5) begin
        sc = m_tgt + longint'($urandom_range(0, 8)) - 4;
        if (sc < 0) sc = 0;
      end else if (r < 9) begin
        sc = longint'($urandom_range(1, 600));
      end else begin
        sc = longint'($urandom);
      end
      window(sc);
    end
    if (m_st != ST_RUN) reenable();

    // Direction reversal through COAST and DWELL.
    target_dir = 1'b1;
    repeat (2) @(negedge clock);
    m_st = ST_COAST; m_duty = 0; m_at = 0; m_stall = 0;
    check("rev_coast", state, 3'(ST_COAST));
    check("rev_duty0", duty, 0);
    check("rev_pwm0", pwm_out, 0);
    window(3);
    window(0);
    measure_dwell("dwell_len");

    // Request toggles back during DWELL; sequence still completes.
    target_dir = 1'b0;
    repeat (2) @(negedge clock);
    m_st = ST_COAST; m_duty = 0; m_at = 0;
    window(0);
    repeat (5) @(negedge clock);
    target_dir = 1'b1;
    repeat (DEAD + 2) @(negedge clock);
    m_st = ST_RUN;
    check("toggle_back_state", state, 3'(ST_RUN));
    check("toggle_back_dir", dir_out, 1);

    // Disable during DWELL, then a full reversal afterwards.
    target_dir = 1'b0;
    repeat (2) @(negedge clock);
    m_st = ST_COAST; m_duty = 0; m_at = 0;
    window(0);
    repeat (10) @(negedge clock);
    reenable();
    window(0);
    measure_dwell("dwell_len2");
    check("dir_final", dir_out, 0);

    repeat (2) @(negedge clock);
    check("sb_leftover", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
